// File: rtl/glb_capture_pkg.sv
// Shared types and helpers for the GLB stream capture block.
package glb_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DONE
    } cap_state_t;

    // Width of a block index; a single block still needs one select bit.
    function automatic int blk_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glb_capture_mem.sv
// 1W1R synchronous buffer holding every block back to back, with a registered
// read port. A read and a write to the same word on one edge return the old word.
module glb_capture_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int WORDS      = 2048,
    parameter int AW         = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Storage write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value while re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/glb_stream_capture.sv
// GLB-side stream sink: captures NUM_BLOCKS size-prefixed blocks from a
// ready/valid stream into on-chip buffers and exposes lengths, a read port
// and completion/overflow status.
module glb_stream_capture
    import glb_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int NUM_BLOCKS = 2,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int BLK_W      = blk_width(NUM_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  rd_en,
    input  logic [BLK_W-1:0]      rd_blk,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] rd_size,
    output logic [NUM_BLOCKS-1:0] blk_done,
    output logic                  done,
    output logic                  overflow
);

    localparam int                CNT_W    = DATA_WIDTH + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [BLK_W-1:0]  LAST_BLK = BLK_W'(NUM_BLOCKS - 1);
    localparam int                MEM_AW   = BLK_W + ADDR_W;

    cap_state_t            state;
    logic                  ready_q;
    logic [BLK_W-1:0]      blk;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [DATA_WIDTH-1:0] sizes [NUM_BLOCKS];
    logic [DATA_WIDTH-1:0] size_cur;
    logic                  xfer;
    logic                  hdr_zero;
    logic                  last_word;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_waddr;
    logic [MEM_AW-1:0]     mem_raddr;

    // A start pulse aborts any run, so the word offered on that edge is refused.
    assign ready     = ready_q & ~start;
    assign xfer      = valid & ready;

    assign size_cur  = sizes[blk];
    assign cnt_nxt   = cnt + 1'b1;
    assign hdr_zero  = (data == '0);
    assign last_word = (cnt_nxt == {1'b0, size_cur});

    // Payload beyond the buffer depth is consumed but never stored.
    assign mem_we    = xfer && (state == PAYLOAD) && (cnt < DEPTH_C);
    assign mem_waddr = {blk, cnt[ADDR_W-1:0]};
    assign mem_raddr = {rd_blk, rd_addr};

    // Length lookup for the read-side block select; unused selects read zero.
    always_comb begin
        rd_size = '0;
        if (int'(rd_blk) < NUM_BLOCKS) begin
            rd_size = sizes[rd_blk];
        end
    end

    // Capture FSM with block/word counters, size registers and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            done     <= 1'b0;
            blk_done <= '0;
            overflow <= 1'b0;
            blk      <= '0;
            cnt      <= '0;
            for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                sizes[i] <= '0;
            end
        end else if (start) begin
            state    <= HDR;
            ready_q  <= 1'b1;
            done     <= 1'b0;
            blk_done <= '0;
            overflow <= 1'b0;
            blk      <= '0;
            cnt      <= '0;
            for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                sizes[i] <= '0;
            end
        end else begin
            case (state)
                HDR: begin
                    if (xfer) begin
                        sizes[blk] <= data;
                        cnt        <= '0;
                        if ({1'b0, data} > DEPTH_C) begin
                            overflow <= 1'b1;
                        end
                        if (hdr_zero) begin
                            blk_done[blk] <= 1'b1;
                            if (blk == LAST_BLK) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                ready_q <= 1'b0;
                            end else begin
                                blk <= blk + 1'b1;
                            end
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        cnt <= cnt_nxt;
                        if (last_word) begin
                            blk_done[blk] <= 1'b1;
                            if (blk == LAST_BLK) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                ready_q <= 1'b0;
                            end else begin
                                blk   <= blk + 1'b1;
                                state <= HDR;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    glb_capture_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (NUM_BLOCKS * DEPTH),
        .AW         (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (data),
        .re      (rd_en),
        .raddr   (mem_raddr),
        .rd_data (rd_data)
    );

endmodule
